// File: rtl/laser_frame_feeder.sv
// laser_frame_feeder
// Upstream companion to the two-circle laser placement core. Host points are
// collected into two ping-pong banks of NPTS points each. Once a bank is full
// and the result slot is free, the core is released from reset and fed the
// frame on NPTS consecutive cycles. The core's result is captured on DONE into
// a valid/ready slot. A watchdog aborts a frame whose DONE never arrives and
// raises a sticky ERR.
//
// Ports:
//   CLK, RST_N                 clock (rising edge), async active-low reset
//   IN_VALID/IN_READY/IN_X/IN_Y host point stream
//   LASER_RST, X, Y            registered reset and point bus to the core
//   DONE, C1X..C2Y             core completion pulse and results
//   RES_VALID/RES_READY        result slot handshake
//   RES_C1X..RES_C2Y           captured results
//   ERR                        sticky watchdog timeout flag
module laser_frame_feeder #(
  parameter int NPTS    = 40,
  parameter int TIMEOUT = 16384
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [3:0] IN_X,
  input  logic [3:0] IN_Y,
  output logic       LASER_RST,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic       RES_VALID,
  input  logic       RES_READY,
  output logic [3:0] RES_C1X,
  output logic [3:0] RES_C1Y,
  output logic [3:0] RES_C2X,
  output logic [3:0] RES_C2Y,
  output logic       ERR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT_DONE
  } state_t;

  localparam logic [5:0]  LAST_PT  = 6'(NPTS - 1);
  localparam logic [5:0]  END_IDX  = 6'(NPTS);
  localparam logic [14:0] WDOG_MAX = 15'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  mem_x [2][NPTS];
  logic [3:0]  mem_y [2][NPTS];

  logic        run;
  logic        wr_bank;
  logic        rd_bank;
  logic [5:0]  wr_cnt;
  logic [1:0]  full;
  logic [1:0]  full_nxt;
  logic        accept;
  logic        wr_last;

  logic [5:0]  idx;
  logic [5:0]  idx_nxt;
  logic [5:0]  rd_ptr;
  logic [3:0]  rd_x;
  logic [3:0]  rd_y;
  logic        lrst_nxt;
  logic [3:0]  x_nxt;
  logic [3:0]  y_nxt;
  logic [14:0] wdog;
  logic [14:0] wdog_nxt;
  logic        rel_bank;
  logic        capture;
  logic        wd_expire;

  // ---- load side: host handshake and bank fill ----
  // run keeps IN_READY low while reset is asserted and for the first edge
  // after release, so the host never sees a ready during reset.
  assign IN_READY = run && !full[wr_bank];
  assign accept   = IN_VALID && IN_READY;
  assign wr_last  = accept && (wr_cnt == LAST_PT);

  always_ff @(posedge CLK) begin
    if (accept) begin
      mem_x[wr_bank][wr_cnt] <= IN_X;
      mem_y[wr_bank][wr_cnt] <= IN_Y;
    end
  end

  // Release and fill always target different banks (a bank being written is
  // empty, a bank being released is full), so both can land on one edge.
  always_comb begin
    full_nxt = full;
    if (rel_bank) full_nxt[rd_bank] = 1'b0;
    if (wr_last)  full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run     <= 1'b0;
      wr_bank <= 1'b0;
      wr_cnt  <= 6'd0;
      full    <= 2'b00;
      rd_bank <= 1'b0;
    end else begin
      run  <= 1'b1;
      full <= full_nxt;
      if (accept) begin
        if (wr_last) begin
          wr_cnt  <= 6'd0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 6'd1;
        end
      end
      if (rel_bank) rd_bank <= ~rd_bank;
    end
  end

  // ---- stream side: frame playback into the core ----
  // In IDLE the launch presents point 0; in STREAM idx already points at the
  // next point to present. idx == NPTS is never used as a read address.
  assign rd_ptr = (state == ST_IDLE) ? 6'd0 : idx;
  assign rd_x   = mem_x[rd_bank][rd_ptr];
  assign rd_y   = mem_y[rd_bank][rd_ptr];

  always_comb begin
    state_nxt = state;
    lrst_nxt  = LASER_RST;
    x_nxt     = X;
    y_nxt     = Y;
    idx_nxt   = idx;
    wdog_nxt  = wdog;
    rel_bank  = 1'b0;
    capture   = 1'b0;
    wd_expire = 1'b0;
    case (state)
      ST_IDLE: begin
        lrst_nxt = 1'b1;
        x_nxt    = 4'd0;
        y_nxt    = 4'd0;
        // Launch waits for a free result slot, so a handshake clear and a
        // launch never share an edge.
        if (full[rd_bank] && !RES_VALID) begin
          state_nxt = ST_STREAM;
          lrst_nxt  = 1'b0;
          x_nxt     = rd_x;
          y_nxt     = rd_y;
          idx_nxt   = 6'd1;
        end
      end
      ST_STREAM: begin
        if (idx == END_IDX) begin
          state_nxt = ST_WAIT_DONE;
          x_nxt     = 4'd0;
          y_nxt     = 4'd0;
          rel_bank  = 1'b1;
          wdog_nxt  = 15'd0;
        end else begin
          x_nxt   = rd_x;
          y_nxt   = rd_y;
          idx_nxt = idx + 6'd1;
        end
      end
      ST_WAIT_DONE: begin
        wdog_nxt = wdog + 15'd1;
        if (DONE) begin
          capture   = 1'b1;
          state_nxt = ST_IDLE;
          lrst_nxt  = 1'b1;
        end else if (wdog == WDOG_MAX) begin
          wd_expire = 1'b1;
          state_nxt = ST_IDLE;
          lrst_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        lrst_nxt  = 1'b1;
        x_nxt     = 4'd0;
        y_nxt     = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      LASER_RST <= 1'b1;
      X         <= 4'd0;
      Y         <= 4'd0;
      idx       <= 6'd0;
      wdog      <= 15'd0;
    end else begin
      state     <= state_nxt;
      LASER_RST <= lrst_nxt;
      X         <= x_nxt;
      Y         <= y_nxt;
      idx       <= idx_nxt;
      wdog      <= wdog_nxt;
    end
  end

  // ---- result slot and error flag ----
  // capture only happens with the slot empty, so it never races a clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RES_VALID <= 1'b0;
      RES_C1X   <= 4'd0;
      RES_C1Y   <= 4'd0;
      RES_C2X   <= 4'd0;
      RES_C2Y   <= 4'd0;
      ERR       <= 1'b0;
    end else begin
      if (capture) begin
        RES_VALID <= 1'b1;
        RES_C1X   <= C1X;
        RES_C1Y   <= C1Y;
        RES_C2X   <= C2X;
        RES_C2Y   <= C2Y;
      end else if (RES_VALID && RES_READY) begin
        RES_VALID <= 1'b0;
      end
      if (wd_expire) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_laser_frame_feeder.sv
// Testbench for laser_frame_feeder. A host process feeds points from a queue
// with a configurable valid probability; every accepted point is recorded in
// a reference queue. Frames are expected to stream in acceptance order, 40
// points at a time. A small core model pulses DONE with chosen results.
module tb_laser_frame_feeder;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [3:0] IN_X = 4'd0;
  logic [3:0] IN_Y = 4'd0;
  logic       LASER_RST;
  logic [3:0] X;
  logic [3:0] Y;
  logic       DONE = 1'b0;
  logic [3:0] C1X = 4'd0;
  logic [3:0] C1Y = 4'd0;
  logic [3:0] C2X = 4'd0;
  logic [3:0] C2Y = 4'd0;
  logic       RES_VALID;
  logic       RES_READY = 1'b1;
  logic [3:0] RES_C1X;
  logic [3:0] RES_C1Y;
  logic [3:0] RES_C2X;
  logic [3:0] RES_C2Y;
  logic       ERR;

  laser_frame_feeder dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_X      (IN_X),
    .IN_Y      (IN_Y),
    .LASER_RST (LASER_RST),
    .X         (X),
    .Y         (Y),
    .DONE      (DONE),
    .C1X       (C1X),
    .C1Y       (C1Y),
    .C2X       (C2X),
    .C2Y       (C2Y),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_C1X   (RES_C1X),
    .RES_C1Y   (RES_C1Y),
    .RES_C2X   (RES_C2X),
    .RES_C2Y   (RES_C2Y),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  localparam int WAIT_MAX = 3000;

  logic [7:0] send_q[$];
  logic [7:0] acc_q[$];
  int         acc_log[$];
  int         valid_pct = 100;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  function automatic int log_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return -1;
  endfunction

  // Host: decide the drive for the next edge; IN_READY is stable between edges.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N && send_q.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
        IN_VALID = 1'b1;
        IN_X     = send_q[0][7:4];
        IN_Y     = send_q[0][3:0];
        if (IN_READY) begin
          acc_q.push_back(send_q.pop_front());
          acc_log.push_back(cyc + 1);
        end
      end else begin
        IN_VALID = 1'b0;
      end
    end
  end

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) send_q.push_back(8'($urandom_range(255)));
  endtask

  // Waits for LASER_RST to fall, then checks npts stream cycles against the
  // next frame of accepted points. With npts == 40 also checks the cycle after.
  task automatic check_frame(input int npts, input bit chk_rdy, output int launch);
    logic [7:0] exp_pts[$];
    bit got = 1'b0;
    int n = 0;
    while (!got && n < WAIT_MAX) begin
      @(negedge CLK);
      n++;
      if (LASER_RST == 1'b0) got = 1'b1;
    end
    if (!got) begin
      expect_eq("launch_wait_expired", 32'd0, 32'd1);
      finish_run();
    end
    launch = cyc;
    expect_eq("frame_complete_at_launch", 32'(acc_q.size() >= 40), 32'd1);
    for (int k = 0; k < 40; k++) begin
      if (acc_q.size() > 0) exp_pts.push_back(acc_q.pop_front());
      else exp_pts.push_back(8'h00);
    end
    for (int k = 0; k < npts; k++) begin
      if (k > 0) @(negedge CLK);
      expect_eq($sformatf("stream_pt%0d", k), 32'({LASER_RST, X, Y}), 32'({1'b0, exp_pts[k]}));
      if (chk_rdy && k == 39) expect_eq("in_ready_both_full", 32'(IN_READY), 32'd0);
    end
    if (npts == 40) begin
      @(negedge CLK);
      expect_eq("wait_done_bus", 32'({LASER_RST, X, Y}), 32'd0);
      if (chk_rdy) expect_eq("in_ready_after_release", 32'(IN_READY), 32'd1);
    end
  endtask

  // Core model: DONE pulse with results after delay cycles of WAIT_DONE.
  task automatic core_done(input int delay, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d, output int r);
    repeat (delay) @(negedge CLK);
    expect_eq("core_running_before_done", 32'(LASER_RST), 32'd0);
    DONE = 1'b1;
    C1X = a; C1Y = b; C2X = c; C2Y = d;
    @(negedge CLK);
    DONE = 1'b0;
    C1X = 4'($urandom_range(15)); C1Y = 4'($urandom_range(15));
    C2X = 4'($urandom_range(15)); C2Y = 4'($urandom_range(15));
    r = cyc;
    expect_eq("res_valid_after_done", 32'(RES_VALID), 32'd1);
    expect_eq("res_values", 32'({RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}), 32'({a, b, c, d}));
    expect_eq("laser_rst_after_done", 32'(LASER_RST), 32'd1);
  endtask

  initial begin
    int l;
    int r;
    int h;
    logic [3:0] v [4];

    // reset values
    repeat (3) @(negedge CLK);
    expect_eq("rst_laser_rst", 32'(LASER_RST), 32'd1);
    expect_eq("rst_xy", 32'({X, Y}), 32'd0);
    expect_eq("rst_in_ready", 32'(IN_READY), 32'd0);
    expect_eq("rst_result_err", 32'({RES_VALID, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, ERR}), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    expect_eq("in_ready_after_reset", 32'(IN_READY), 32'd1);

    // frames A and B back to back, continuous valid
    #1;
    for (int i = 0; i < 80; i++) send_q.push_back({4'(i % 16), 4'(i / 16)});
    check_frame(40, 1'b1, l);
    expect_eq("a_launch_cycle", 32'(l), 32'(log_at(39) + 1));
    expect_eq("80_consecutive_accepts", 32'(log_at(79) - log_at(0)), 32'd79);
    core_done(499, 4'd3, 4'd4, 4'd11, 4'd9, r);

    // B: slot drains next edge, LASER_RST held, then B launches. Frame C is
    // timed so its 40th point lands on the same edge B's bank is released.
    @(negedge CLK);
    expect_eq("hold_laser_rst", 32'({LASER_RST, RES_VALID}), 32'b10);
    #1 push_random(40);
    check_frame(40, 1'b0, l);
    expect_eq("b_launch_cycle", 32'(l), 32'(r + 2));
    expect_eq("c_fill_meets_release", 32'(log_at(119)), 32'(l + 40));
    expect_eq("in_ready_after_sim_release", 32'(IN_READY), 32'd1);

    // B result held in the slot blocks launch of C
    RES_READY = 1'b0;
    for (int i = 0; i < 4; i++) v[i] = 4'($urandom_range(15));
    core_done(50 + int'($urandom_range(250)), v[0], v[1], v[2], v[3], r);
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK);
      expect_eq($sformatf("blocked_launch_%0d", i), 32'({LASER_RST, RES_VALID}), 32'b11);
    end
    expect_eq("res_retained", 32'({RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}), 32'({v[0], v[1], v[2], v[3]}));
    RES_READY = 1'b1;
    h = cyc + 1;
    @(negedge CLK);
    RES_READY = 1'b0;
    expect_eq("slot_cleared", 32'({LASER_RST, RES_VALID}), 32'b10);
    check_frame(40, 1'b0, l);
    expect_eq("c_launch_after_handshake", 32'(l), 32'(h + 1));
    RES_READY = 1'b1;

    // C never completes: watchdog
    repeat (16383) @(negedge CLK);
    expect_eq("wdog_last_wait_cycle", 32'({ERR, LASER_RST}), 32'b00);
    @(negedge CLK);
    expect_eq("wdog_err_rst", 32'({ERR, LASER_RST, RES_VALID}), 32'b110);

    // stray DONE in IDLE is ignored
    DONE = 1'b1;
    C1X = 4'd5; C1Y = 4'd6; C2X = 4'd7; C2Y = 4'd8;
    @(negedge CLK);
    DONE = 1'b0;
    expect_eq("stray_done_ignored", 32'({RES_VALID, LASER_RST}), 32'b01);

    // frame D with 50% valid
    acc_log.delete();
    valid_pct = 50;
    #1 push_random(40);
    check_frame(40, 1'b0, l);
    expect_eq("d_launch_after_last_point", 32'(l), 32'(log_at(39) + 1));
    for (int i = 0; i < 4; i++) v[i] = 4'($urandom_range(15));
    core_done(1 + int'($urandom_range(300)), v[0], v[1], v[2], v[3], r);
    expect_eq("err_sticky", 32'(ERR), 32'd1);

    // frame E, reset in mid-stream at idx 17, partial frame F dropped
    valid_pct = 100;
    push_random(50);
    check_frame(17, 1'b0, l);
    RST_N = 1'b0;
    #1;
    expect_eq("midrst_laser_rst", 32'(LASER_RST), 32'd1);
    expect_eq("midrst_xy", 32'({X, Y}), 32'd0);
    expect_eq("midrst_in_ready", 32'(IN_READY), 32'd0);
    expect_eq("midrst_err_res", 32'({ERR, RES_VALID}), 32'd0);
    send_q.delete();
    acc_q.delete();
    acc_log.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    expect_eq("in_ready_after_midrst", 32'(IN_READY), 32'd1);
    valid_pct = 50;
    #1 push_random(40);
    check_frame(40, 1'b0, l);
    expect_eq("g_launch_after_last_point", 32'(l), 32'(log_at(39) + 1));
    for (int i = 0; i < 4; i++) v[i] = 4'($urandom_range(15));
    core_done(1 + int'($urandom_range(200)), v[0], v[1], v[2], v[3], r);

    finish_run();
  end

endmodule
